urna: RTL and testbench

URNA -- requirements
Module: urna

---
 rtl/urna_if.sv | 23 ++
 rtl/urna.sv | 102 ++++++++++
 tb/tb_urna.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/urna_if.sv
// Voting-station bus: session control, voter strobes/values and latched results.
interface urna_if;
  logic       start;
  logic [2:0] press;
  logic [2:0] choice;
  logic       a;
  logic       b;
  logic       c;
  logic [2:0] voted;
  logic       open;
  logic       done;
  logic       partial;

  modport master (
    output start, press, choice,
    input  a, b, c, voted, open, done, partial
  );

  modport slave (
    input  start, press, choice,
    output a, b, c, voted, open, done, partial
  );
endinterface

// File: rtl/urna.sv
// URNA: three-voter ballot box. Opens a timed voting window on start, latches
// each voter's first vote, and closes when everyone has voted or the window
// expires. Votes feed a downstream majority voter; abstentions read as 0.
module urna #(
  parameter int unsigned TMAX = 100
) (
  input  logic   clk,
  input  logic   reset_n,
  urna_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_RESULT = 2'b10
  } state_t;

  // Window counter value on the last open cycle.
  localparam logic [15:0] LAST_CNT = 16'(TMAX - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  votes_q, votes_d;
  logic [2:0]  voted_q, voted_d;
  logic        open_q, open_d;
  logic        done_q, done_d;
  logic        partial_q, partial_d;
  logic [2:0]  accept_s;

  // Next-state, vote latching and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    votes_d   = votes_q;
    voted_d   = voted_q;
    accept_s  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_OPEN;
          cnt_d   = 16'd0;
          votes_d = 3'b000;
          voted_d = 3'b000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        // Only a voter's first press counts; later presses are ignored.
        accept_s = bus.press & ~voted_q;
        votes_d  = (votes_q & ~accept_s) | (bus.choice & accept_s);
        voted_d  = voted_q | accept_s;
        cnt_d    = cnt_q + 16'd1;
        if ((voted_d == 3'b111) || (cnt_q == LAST_CNT)) begin
          state_d = ST_RESULT;
        end else begin
          state_d = ST_OPEN;
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    open_d    = (state_d == ST_OPEN);
    done_d    = (state_d == ST_RESULT);
    // All-voted wins over a same-edge timeout since voted_d already includes it.
    partial_d = done_d && (voted_d != 3'b111);
  end

  // State and output registers with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      votes_q   <= 3'b000;
      voted_q   <= 3'b000;
      open_q    <= 1'b0;
      done_q    <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      votes_q   <= votes_d;
      voted_q   <= voted_d;
      open_q    <= open_d;
      done_q    <= done_d;
      partial_q <= partial_d;
    end
  end

  assign bus.a       = votes_q[0];
  assign bus.b       = votes_q[1];
  assign bus.c       = votes_q[2];
  assign bus.voted   = voted_q;
  assign bus.open    = open_q;
  assign bus.done    = done_q;
  assign bus.partial = partial_q;

endmodule

// File: tb/tb_urna.sv
// Self-checking bench for urna (TMAX = 8): directed scenarios plus a random
// run compared against a session-level behavioural model.
module tb_urna;

  localparam int TMAX = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  urna_if ifc ();

  urna #(.TMAX(TMAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: is a session running, has it just closed, who voted what.
  bit         m_open;
  bit         m_done;
  bit         m_partial;
  logic [2:0] m_votes;
  logic [2:0] m_has;
  int         m_elapsed;

  function automatic void model_reset();
    m_open    = 1'b0;
    m_done    = 1'b0;
    m_partial = 1'b0;
    m_votes   = 3'b000;
    m_has     = 3'b000;
    m_elapsed = 0;
  endfunction

  function automatic void model_step(input logic st, input logic [2:0] pr, input logic [2:0] ch);
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_open) begin
      if (st) begin
        m_open    = 1'b1;
        m_votes   = 3'b000;
        m_has     = 3'b000;
        m_elapsed = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pr[i] && !m_has[i]) begin
          m_votes[i] = ch[i];
          m_has[i]   = 1'b1;
        end
      end
      m_elapsed++;
      if (m_has == 3'b111 || m_elapsed == TMAX) begin
        m_open = 1'b0;
        m_done = 1'b1;
      end
    end
    m_partial = m_done && (m_has != 3'b111);
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic st, input logic [2:0] pr, input logic [2:0] ch);
    ifc.start  = st;
    ifc.press  = pr;
    ifc.choice = ch;
    model_step(st, pr, ch);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    ifc.start  = 1'b0;
    ifc.press  = 3'b000;
    ifc.choice = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open, ifc.done, ifc.partial} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b",
               {ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open, ifc.done, ifc.partial}, 9'd0);
    end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_all_voters();
    cycle(1'b1, 3'b000, 3'b000);
    checks++;
    if (ifc.open !== 1'b1 || ifc.done !== 1'b0) begin
      failures++;
      $display("FAIL allv_open got open=%b done=%b want open=1 done=0", ifc.open, ifc.done);
    end
    cycle(1'b0, 3'b111, 3'b101);
    checks++;
    if ({ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open} !== 9'b1_0_101_111_0) begin
      failures++;
      $display("FAIL allv_close got=%b want=%b",
               {ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open}, 9'b1_0_101_111_0);
    end
    cycle(1'b0, 3'b000, 3'b000);
    checks++;
    if ({ifc.done, ifc.open, ifc.c, ifc.b, ifc.a, ifc.voted} !== 8'b0_0_101_111) begin
      failures++;
      $display("FAIL allv_hold got=%b want=%b",
               {ifc.done, ifc.open, ifc.c, ifc.b, ifc.a, ifc.voted}, 8'b0_0_101_111);
    end
  endtask

  task automatic test_staggered();
    int dones;
    dones = 0;
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b001, 3'b001);
    dones += int'(ifc.done);
    cycle(1'b0, 3'b010, 3'b000);
    dones += int'(ifc.done);
    cycle(1'b0, 3'b001, 3'b000);
    dones += int'(ifc.done);
    checks++;
    if (ifc.a !== 1'b1 || ifc.voted !== 3'b011) begin
      failures++;
      $display("FAIL stag_repeat got a=%b voted=%b want a=1 voted=011", ifc.a, ifc.voted);
    end
    cycle(1'b0, 3'b100, 3'b100);
    checks++;
    if (ifc.done !== 1'b1 || ifc.partial !== 1'b0 || {ifc.c, ifc.b, ifc.a} !== 3'b101) begin
      failures++;
      $display("FAIL stag_close got done=%b partial=%b cba=%b want 1 0 101",
               ifc.done, ifc.partial, {ifc.c, ifc.b, ifc.a});
    end
    dones += int'(ifc.done);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b000, 3'b000);
      dones += int'(ifc.done);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL stag_done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_timeout();
    int  open_cycles;
    bit  seen;
    cycle(1'b1, 3'b000, 3'b000);
    open_cycles = int'(ifc.open);
    seen = 1'b0;
    cycle(1'b0, 3'b010, 3'b010);
    open_cycles += int'(ifc.open);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ifc.done) begin
        seen = 1'b1;
      end else begin
        cycle(1'b0, 3'b000, 3'b000);
        open_cycles += int'(ifc.open);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL tmo_done_seen got=0 want=1");
    end
    checks++;
    if (open_cycles !== TMAX) begin
      failures++;
      $display("FAIL tmo_open_len got=%0d want=%0d", open_cycles, TMAX);
    end
    checks++;
    if ({ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted} !== 7'b1_010_010) begin
      failures++;
      $display("FAIL tmo_result got=%b want=%b",
               {ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted}, 7'b1_010_010);
    end
    cycle(1'b0, 3'b000, 3'b000);
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b011, 3'b011);
    for (int i = 0; i < TMAX - 2; i++) cycle(1'b0, 3'b000, 3'b000);
    checks++;
    if (ifc.open !== 1'b1 || ifc.done !== 1'b0) begin
      failures++;
      $display("FAIL simul_still_open got open=%b done=%b want 1 0", ifc.open, ifc.done);
    end
    cycle(1'b0, 3'b100, 3'b000);
    checks++;
    if ({ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted} !== 8'b1_0_011_111) begin
      failures++;
      $display("FAIL simul_close got=%b want=%b",
               {ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted}, 8'b1_0_011_111);
    end
    cycle(1'b0, 3'b000, 3'b000);
  endtask

  task automatic test_ignored();
    logic [2:0] prev_votes;
    logic [2:0] prev_voted;
    int         open_cycles;
    bit         seen;
    prev_votes = m_votes;
    prev_voted = m_has;
    cycle(1'b0, 3'b111, 3'b000);
    checks++;
    if ({ifc.open, ifc.done, ifc.c, ifc.b, ifc.a, ifc.voted} !== {2'b00, prev_votes, prev_voted}) begin
      failures++;
      $display("FAIL ign_idle_press got=%b want=%b",
               {ifc.open, ifc.done, ifc.c, ifc.b, ifc.a, ifc.voted}, {2'b00, prev_votes, prev_voted});
    end
    cycle(1'b1, 3'b000, 3'b000);
    open_cycles = int'(ifc.open);
    cycle(1'b1, 3'b001, 3'b001);
    open_cycles += int'(ifc.open);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ifc.done) begin
        seen = 1'b1;
      end else begin
        cycle(1'b1, 3'b000, 3'b000);
        open_cycles += int'(ifc.open);
      end
    end
    checks++;
    if (!seen || open_cycles !== TMAX || ifc.partial !== 1'b1 || ifc.voted !== 3'b001) begin
      failures++;
      $display("FAIL ign_start_in_open got seen=%0d open_len=%0d partial=%b voted=%b want 1 %0d 1 001",
               seen, open_cycles, ifc.partial, ifc.voted, TMAX);
    end
    cycle(1'b0, 3'b000, 3'b000);
  endtask

  task automatic test_reset_mid();
    bit seen;
    cycle(1'b1, 3'b000, 3'b000);
    cycle(1'b0, 3'b001, 3'b001);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open, ifc.done, ifc.partial} !== 9'd0) begin
      failures++;
      $display("FAIL rstmid_async got=%b want=%b",
               {ifc.c, ifc.b, ifc.a, ifc.voted, ifc.open, ifc.done, ifc.partial}, 9'd0);
    end
    #1 reset_n = 1'b1;
    cycle(1'b1, 3'b000, 3'b000);
    checks++;
    if (ifc.open !== 1'b1 || ifc.done !== 1'b0 || ifc.voted !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_restart got open=%b done=%b voted=%b want 1 0 000",
               ifc.open, ifc.done, ifc.voted);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 3'b111, 3'b110);
      seen = ifc.done;
    end
    checks++;
    if (!seen || {ifc.c, ifc.b, ifc.a} !== 3'b110) begin
      failures++;
      $display("FAIL rstmid_session got seen=%0d cba=%b want 1 110", seen, {ifc.c, ifc.b, ifc.a});
    end
    cycle(1'b0, 3'b000, 3'b000);
  endtask

  task automatic test_random();
    logic st;
    logic [2:0] pr;
    logic [2:0] ch;
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 3) == 0);
      pr = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      ch = 3'($urandom);
      cycle(st, pr, ch);
      checks++;
      if ({ifc.open, ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted} !==
          {m_open, m_done, m_partial, m_votes, m_has}) begin
        failures++;
        bad++;
        if (bad <= 10) begin
          $display("FAIL rand_cycle%0d got=%b want=%b", n,
                   {ifc.open, ifc.done, ifc.partial, ifc.c, ifc.b, ifc.a, ifc.voted},
                   {m_open, m_done, m_partial, m_votes, m_has});
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_all_voters();
    test_staggered();
    test_timeout();
    test_simultaneous();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
